// File: rtl/cnn_ring_pkg.sv
// Shared constants and state type for the one-hot ring address sequencer that
// feeds the 15-bit one-hot to 4-bit address encoder.
package cnn_ring_pkg;

    localparam int RING_LEN = 15;

    // Ring order seen by the encoder: bit14 is address 0, bit13 is address 14.
    localparam logic [RING_LEN-1:0] RING_FIRST    = 15'h4000;
    localparam logic [RING_LEN-1:0] RING_LAST     = 15'h2000;
    localparam logic [3:0]          ENC_IDLE_ADDR = 4'hF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_e;

    function automatic logic ring_is_onehot(input logic [RING_LEN-1:0] ring);
        return (ring != '0) && ((ring & (ring - RING_LEN'(1))) == '0);
    endfunction

endpackage

// File: rtl/ring_shift_reg.sv
// One-hot rotate register: clear wins over load-first, which wins over shift.
// A left rotate walks bit14 -> bit0 -> bit1 ... -> bit13.
module ring_shift_reg
    import cnn_ring_pkg::*;
(
    input  logic                clk,
    input  logic                i_rst,
    input  logic                i_clear,
    input  logic                i_load_first,
    input  logic                i_shift_en,
    output logic [RING_LEN-1:0] o_ring
);

    logic [RING_LEN-1:0] r_ring;
    logic [RING_LEN-1:0] w_rot;

    generate
        for (genvar gi = 0; gi < RING_LEN; gi++) begin : g_rot
            assign w_rot[gi] = r_ring[(gi + RING_LEN - 1) % RING_LEN];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (i_rst || i_clear) begin
            r_ring <= '0;
        end else if (i_load_first) begin
            r_ring <= RING_FIRST;
        end else if (i_shift_en) begin
            r_ring <= w_rot;
        end
    end

    assign o_ring = r_ring;

endmodule

// File: rtl/ring_addr_sequencer.sv
// Start/done sequencer producing the one-hot address ring, with per-position
// dwell, multi-pass repetition, stall and abort.
module ring_addr_sequencer
    import cnn_ring_pkg::*;
#(
    parameter int DWELL_W = 4,
    parameter int PASS_W  = 4
)
(
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic                stall,
    input  logic [DWELL_W-1:0]  cfg_dwell,
    input  logic [PASS_W-1:0]   cfg_passes,
    output logic [RING_LEN-1:0] ring_out,
    output logic                valid,
    output logic                last,
    output logic                busy,
    output logic                done,
    output logic [PASS_W-1:0]   pass_idx
);

    seq_state_e          r_state;
    seq_state_e          w_state_next;
    logic [DWELL_W-1:0]  r_dwell_cnt;
    logic [DWELL_W-1:0]  w_dwell_next;
    logic [DWELL_W-1:0]  r_cfg_dwell;
    logic [DWELL_W-1:0]  w_cfg_dwell_next;
    logic [PASS_W-1:0]   r_pass_idx;
    logic [PASS_W-1:0]   w_pass_next;
    logic [PASS_W-1:0]   r_last_pass;
    logic [PASS_W-1:0]   w_last_pass_next;
    logic                w_ring_clear;
    logic                w_ring_load;
    logic                w_ring_shift;
    logic [RING_LEN-1:0] w_ring;
    logic                w_at_last;
    logic                w_final_pass;
    logic                w_dwell_full;

    ring_shift_reg u_ring (
        .clk          (clk),
        .i_rst        (rst),
        .i_clear      (w_ring_clear),
        .i_load_first (w_ring_load),
        .i_shift_en   (w_ring_shift),
        .o_ring       (w_ring)
    );

    assign w_at_last    = (w_ring == RING_LAST);
    assign w_final_pass = (r_pass_idx == r_last_pass);
    assign w_dwell_full = (r_dwell_cnt == r_cfg_dwell);

    always_comb begin
        w_state_next     = r_state;
        w_dwell_next     = r_dwell_cnt;
        w_pass_next      = r_pass_idx;
        w_cfg_dwell_next = r_cfg_dwell;
        w_last_pass_next = r_last_pass;
        w_ring_clear     = 1'b0;
        w_ring_load      = 1'b0;
        w_ring_shift     = 1'b0;

        case (r_state)
            IDLE: begin
                if (start && !abort) begin
                    w_state_next     = RUN;
                    w_dwell_next     = '0;
                    w_pass_next      = '0;
                    w_cfg_dwell_next = cfg_dwell;
                    // A pass count of zero still runs one full ring.
                    w_last_pass_next = (cfg_passes == '0) ? '0 : cfg_passes - PASS_W'(1);
                    w_ring_load      = 1'b1;
                end
            end

            RUN: begin
                if (abort) begin
                    w_state_next = IDLE;
                    w_dwell_next = '0;
                    w_ring_clear = 1'b1;
                end else if (!ring_is_onehot(w_ring)) begin
                    w_state_next = IDLE;
                    w_dwell_next = '0;
                    w_pass_next  = '0;
                    w_ring_clear = 1'b1;
                end else if (!stall) begin
                    if (!w_dwell_full) begin
                        w_dwell_next = r_dwell_cnt + DWELL_W'(1);
                    end else begin
                        w_dwell_next = '0;
                        if (!w_at_last) begin
                            w_ring_shift = 1'b1;
                        end else if (!w_final_pass) begin
                            w_ring_load = 1'b1;
                            w_pass_next = r_pass_idx + PASS_W'(1);
                        end else begin
                            w_state_next = DONE;
                            w_ring_clear = 1'b1;
                        end
                    end
                end
            end

            DONE: begin
                w_state_next = IDLE;
                w_dwell_next = '0;
            end

            default: begin
                w_state_next = IDLE;
                w_dwell_next = '0;
                w_pass_next  = '0;
                w_ring_clear = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_dwell_cnt <= '0;
            r_pass_idx  <= '0;
            r_cfg_dwell <= '0;
            r_last_pass <= '0;
        end else begin
            r_state     <= w_state_next;
            r_dwell_cnt <= w_dwell_next;
            r_pass_idx  <= w_pass_next;
            r_cfg_dwell <= w_cfg_dwell_next;
            r_last_pass <= w_last_pass_next;
        end
    end

    assign ring_out = w_ring;
    assign valid    = (r_state == RUN);
    assign busy     = (r_state == RUN);
    assign done     = (r_state == DONE);
    assign last     = (r_state == RUN) && w_at_last && w_final_pass;
    assign pass_idx = r_pass_idx;

endmodule

// File: doc/ring_addr_sequencer.md
Name: ring_addr_sequencer

Overview:
- Sequential stage directly upstream of the 15-bit one-hot to 4-bit address encoder in CNN_Single_Layer.
- Generates the 15-position one-hot ring that the encoder turns into addresses 0..14.
- Adds start/done handshake, per-position dwell, multi-pass repetition, stall and abort.
- Ring order matches the encoder: bit14 (addr 0), bit0 (addr 1), bit1 (addr 2) … bit13 (addr 14). All-zero drives the encoder default of 15, which means idle.

Parameters:
RING_LEN, 15, ring width; fixed by the downstream encoder.
DWELL_W, 4, width of dwell configuration (extra cycles per position).
PASS_W, 4, width of pass-count configuration.

Ports:
clk  in  1  rising-edge clock.
rst  in  1  synchronous, active-high reset.
start  in  1  begin a sequence; sampled only in IDLE.
abort  in  1  synchronous cancel; returns to IDLE without done.
stall  in  1  downstream back-pressure; freezes the sequencer.
cfg_dwell  in  DWELL_W  extra hold cycles per position; latched on accepted start.
cfg_passes  in  PASS_W  number of full ring passes; latched on accepted start; 0 is treated as 1.
ring_out  out  RING_LEN  one-hot ring; feeds the encoder AddrIn.
valid  out  1  ring_out is a live position.
last  out  1  ring_out is at bit13 on the final pass.
busy  out  1  sequence in progress.
done  out  1  one-cycle pulse after the final position retires.
pass_idx  out  PASS_W  current pass, 0-based.

Behaviour:
- Reset (rst=1 at clk edge): state=IDLE, ring_out=0, valid=0, last=0, busy=0, done=0, pass_idx=0, dwell counter=0. Reset overrides every other input.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 and abort=0 at edge N: latch the configuration. From cycle N+1: ring_out=15'h4000, valid=1, busy=1, state=RUN, dwell_cnt=0, pass_idx=0.
  - start=0: all outputs hold their reset values.
- RUN, stall=1: ring_out, dwell_cnt, pass_idx and state freeze. valid stays 1.
- RUN, stall=0 and dwell_cnt<cfg_dwell: dwell_cnt+1.
- RUN, stall=0 and dwell_cnt==cfg_dwell (position retires):
  - dwell_cnt becomes 0.
  - If not at bit13: rotate left, ring_out={ring_out[13:0],ring_out[14]}.
  - If at bit13 and pass_idx<passes-1: ring_out=15'h4000 and pass_idx+1 (wrap-around).
  - If at bit13 on the final pass: go to DONE. Next cycle ring_out=0, valid=0, busy=0, last=0, done=1.
- DONE: lasts exactly one cycle, then IDLE with done=0. pass_idx holds its final value until the next start.
- last=1 whenever state=RUN, ring_out==15'h2000 and pass_idx==passes-1, including during dwell and stall cycles.
- Each position is valid for cfg_dwell+1 non-stalled cycles.
- Without stall, busy lasts 15*P*(D+1) cycles, with done in the following cycle (P=effective passes, D=cfg_dwell).
- abort=1 in RUN or DONE: next cycle IDLE, ring_out=0, valid=0, busy=0, no done pulse. abort has priority over stall and over start in IDLE.
- start while busy is ignored. A configuration change during RUN has no effect.
- Illegal state: ring_out not one-hot while in RUN. This is unreachable. Synthesis recovery: force IDLE with outputs at reset values.

Decomposition:
- Shared package cnn_ring_pkg: RING_LEN=15, RING_FIRST=15'h4000, RING_LAST=15'h2000, ENC_IDLE_ADDR=4'hF, and the state enum {IDLE, RUN, DONE}.
- One natural sub-module, ring_shift_reg: one-hot rotate register with clear, load-first and shift-enable inputs.
- The FSM, dwell counter and pass counter live in ring_addr_sequencer.

Test Plan:
1. Reset then idle:
   - Stimulus: rst for 2 cycles, then 5 idle cycles.
   - Required: ring_out=0, valid=0, busy=0, done=0 throughout. Encoder address reads 15.
2. Single pass, no dwell:
   - Stimulus: cfg_dwell=0, cfg_passes=1, start pulse.
   - Required: the encoder sees addresses 0,1,…,14 on 15 consecutive cycles. last=1 only on the addr-14 cycle. done=1 on cycle 16 after the start edge.
3. Dwell plus two passes:
   - Stimulus: cfg_dwell=2, cfg_passes=2.
   - Required: each position is held 3 cycles and busy lasts 90 cycles. pass_idx goes 0→1 at the wrap from 15'h2000 to 15'h4000. last is asserted for the final 3 busy cycles.
4. Stall mid-run:
   - Stimulus: cfg_dwell=0, stall=1 for 4 cycles while ring_out=15'h0008.
   - Required: ring_out stays 15'h0008 and valid stays 1 for 4 extra cycles. Total busy is 19 cycles.
5. Abort and restart:
   - Stimulus: abort at position bit5, then start with cfg_passes=0.
   - Required: next cycle ring_out=0, busy=0, done never pulses. The restart runs exactly 1 pass.
6. Control contention:
   - Stimulus: start during RUN; then start and abort together in IDLE; then rst asserted mid-run.
   - Required: the RUN start is ignored. start+abort stays in IDLE. rst gives reset values at the next edge.
